mul_share_arb: RTL and testbench

//  Arbitrates one 27x27 multiplier slice (mul0: en/req_in_1/req_in_2 -> 54b out, fixed latency)

---
 rtl/fma_pkg.sv | 22 ++
 rtl/mul_share_arb_rr_pick.sv | 31 +++
 rtl/mul_share_arb.sv | 119 +++++++++++
 tb/tb_mul_share_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Shared FMA datapath types: mul0 port bundles, operand/product widths, default mul latency.
package fma_pkg;
  localparam int MUL_W       = 27;
  localparam int PROD_W      = 54;
  localparam int MUL_LAT_DEF = 2;

  typedef struct packed {
    logic             en;
    logic [MUL_W-1:0] req_in_1;
    logic [MUL_W-1:0] req_in_2;
  } mulit;

  typedef struct packed {
    logic [PROD_W-1:0] out;
  } mulot;

  typedef enum logic {LK_IDLE, LK_LOCKED} lock_st_e;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/mul_share_arb_rr_pick.sv
// Rotate-priority picker: first set request at/after ptr_i, wrapping, as one-hot plus index.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any_o && req_i[jj]) begin
        any_o     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end
endmodule

// File: rtl/mul_share_arb.sv
// Round-robin sharing of one mul0 slice among NREQ requesters with a tagged return pipe.
// Optional MUL_SHARE_ARB_LOCK_EN adds req_lock for back-to-back ops by one owner.
module mul_share_arb
  import fma_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0][MUL_W-1:0]  req_in_1,
  input  logic [NREQ-1:0][MUL_W-1:0]  req_in_2,
`ifdef MUL_SHARE_ARB_LOCK_EN
  input  logic [NREQ-1:0]             req_lock,
`endif
  output logic [NREQ-1:0]             req_ready,
  output logic [NREQ-1:0]             rsp_valid,
  output logic [PROD_W-1:0]           rsp_out,
  output logic                        idle,
  output mulit                        muli,
  input  mulot                        mulo
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]                ptr_q, ptr_d;
  logic [NREQ-1:0]              elig, gnt;
  logic [IW-1:0]                win;
  logic                         any, issue, lock_idle;
  logic [MUL_LAT-1:0]           tag_v_q, tag_v_d;
  logic [MUL_LAT-1:0][IW-1:0]   tag_id_q, tag_id_d;

`ifdef MUL_SHARE_ARB_LOCK_EN
  lock_st_e        st_q, st_d;
  logic [IW-1:0]   own_q, own_d;
  logic [NREQ-1:0] own_oh;

  // While locked only the owner competes, so the picker returns it regardless of ptr.
  assign own_oh    = NREQ'(1) << own_q;
  assign elig      = (st_q == LK_LOCKED) ? (req_valid & own_oh) : req_valid;
  assign lock_idle = (st_q == LK_IDLE);
`else
  assign elig      = req_valid;
  assign lock_idle = 1'b1;
`endif

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win),
    .any_o (any)
  );

  assign req_ready     = reset ? '0 : gnt;
  assign issue         = any & ~reset;
  assign muli.en       = issue;
  assign muli.req_in_1 = issue ? req_in_1[win] : '0;
  assign muli.req_in_2 = issue ? req_in_2[win] : '0;

  always_comb begin
    ptr_d = ptr_q;
`ifdef MUL_SHARE_ARB_LOCK_EN
    st_d  = st_q;
    own_d = own_q;
    if (st_q == LK_LOCKED) begin
      // Owner leaves by issuing unlocked or by dropping valid; either way rr resumes after it.
      if (!req_valid[own_q] || !req_lock[own_q]) begin
        st_d  = LK_IDLE;
        ptr_d = IW'(wrap_inc(int'(own_q), NREQ));
      end
    end else if (issue) begin
      ptr_d = IW'(wrap_inc(int'(win), NREQ));
      if (req_lock[win]) begin
        st_d  = LK_LOCKED;
        own_d = win;
      end
    end
`else
    if (issue) ptr_d = IW'(wrap_inc(int'(win), NREQ));
`endif
    tag_v_d     = tag_v_q;
    tag_id_d    = tag_id_q;
    tag_v_d[0]  = issue;
    tag_id_d[0] = win;
    for (int k = 1; k < MUL_LAT; k++) begin
      tag_v_d[k]  = tag_v_q[k-1];
      tag_id_d[k] = tag_id_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      tag_v_q  <= '0;
      tag_id_q <= '0;
`ifdef MUL_SHARE_ARB_LOCK_EN
      st_q     <= LK_IDLE;
      own_q    <= '0;
`endif
    end else begin
      ptr_q    <= ptr_d;
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
`ifdef MUL_SHARE_ARB_LOCK_EN
      st_q     <= st_d;
      own_q    <= own_d;
`endif
    end
  end

  // Last tag stage lines up with mul0's output for the same op.
  for (genvar i = 0; i < NREQ; i++) begin : g_rsp
    assign rsp_valid[i] = ~reset & tag_v_q[MUL_LAT-1] & (tag_id_q[MUL_LAT-1] == IW'(i));
  end

  assign rsp_out = mulo.out;
  assign idle    = reset | (~|tag_v_q & lock_idle);
endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: directed scenarios on 2- and 4-requester instances plus a
// randomized 3-requester run against a round-robin/scoreboard reference model.
module tb_mul_share_arb;
  import fma_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // NREQ=2, MUL_LAT=2
  logic            rst2 = 1'b1;
  logic [1:0]      v2 = '0, rdy2, rv2;
  logic [1:0][26:0] a2 = '0, b2 = '0;
  logic [53:0]     ro2;
  logic            idle2;
  mulit            mi2;
  mulot            mo2;
  logic [53:0]     mp2 [2];
  logic [1:0]      lk2 = '0;

  // NREQ=4, MUL_LAT=2
  logic            rst4 = 1'b1;
  logic [3:0]      v4 = '0, rdy4, rv4;
  logic [3:0][26:0] a4 = '0, b4 = '0;
  logic [53:0]     ro4;
  logic            idle4;
  mulit            mi4;
  mulot            mo4;
  logic [53:0]     mp4 [2];
  logic [3:0]      lk4 = '0;

  // NREQ=3, MUL_LAT=3
  logic            rst3 = 1'b1;
  logic [2:0]      v3 = '0, rdy3, rv3;
  logic [2:0][26:0] a3 = '0, b3 = '0;
  logic [53:0]     ro3;
  logic            idle3;
  mulit            mi3;
  mulot            mo3;
  logic [53:0]     mp3 [3];
  logic [2:0]      lk3 = '0;

  mul_share_arb #(.NREQ(2), .MUL_LAT(2)) dut2 (
    .clk(clk), .reset(rst2), .req_valid(v2), .req_in_1(a2), .req_in_2(b2),
`ifdef MUL_SHARE_ARB_LOCK_EN
    .req_lock(lk2),
`endif
    .req_ready(rdy2), .rsp_valid(rv2), .rsp_out(ro2), .idle(idle2), .muli(mi2), .mulo(mo2));

  mul_share_arb #(.NREQ(4), .MUL_LAT(2)) dut4 (
    .clk(clk), .reset(rst4), .req_valid(v4), .req_in_1(a4), .req_in_2(b4),
`ifdef MUL_SHARE_ARB_LOCK_EN
    .req_lock(lk4),
`endif
    .req_ready(rdy4), .rsp_valid(rv4), .rsp_out(ro4), .idle(idle4), .muli(mi4), .mulo(mo4));

  mul_share_arb #(.NREQ(3), .MUL_LAT(3)) dut3 (
    .clk(clk), .reset(rst3), .req_valid(v3), .req_in_1(a3), .req_in_2(b3),
`ifdef MUL_SHARE_ARB_LOCK_EN
    .req_lock(lk3),
`endif
    .req_ready(rdy3), .rsp_valid(rv3), .rsp_out(ro3), .idle(idle3), .muli(mi3), .mulo(mo3));

  function automatic logic [53:0] pr(input logic [26:0] x, input logic [26:0] y);
    return {27'b0, x} * {27'b0, y};
  endfunction

  // mul0 stand-ins: fixed-latency multipliers
  always @(posedge clk) begin
    mp2[0] <= mi2.en ? pr(mi2.req_in_1, mi2.req_in_2) : '0;
    mp2[1] <= mp2[0];
    mp4[0] <= mi4.en ? pr(mi4.req_in_1, mi4.req_in_2) : '0;
    mp4[1] <= mp4[0];
    mp3[0] <= mi3.en ? pr(mi3.req_in_1, mi3.req_in_2) : '0;
    mp3[1] <= mp3[0];
    mp3[2] <= mp3[1];
  end
  assign mo2.out = mp2[1];
  assign mo4.out = mp4[1];
  assign mo3.out = mp3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_dut2();
    rst2 = 1'b1; v2 = '0; lk2 = '0;
    tick();
    rst2 = 1'b0;
  endtask

  task automatic test_reset();
    rst2 = 1'b1; v2 = 2'b11; a2[0] = 27'd7; b2[0] = 27'd9;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++; if (rdy2 !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", rdy2); end
      checks++; if (rv2 !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rv2); end
      checks++; if (idle2 !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle2); end
      checks++; if (mi2.en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", mi2.en); end
      tick();
    end
    rst2 = 1'b0; v2 = '0;
    #2;
    checks++; if (idle2 !== 1'b1) begin errors++; $display("FAIL post_reset_idle got %b exp 1", idle2); end
    tick();
  endtask

  task automatic test_single();
    v2 = 2'b01; a2[0] = 27'd3; b2[0] = 27'd5;
    #2;
    checks++; if (mi2.en !== 1'b1) begin errors++; $display("FAIL single_en got %b exp 1", mi2.en); end
    checks++; if (rdy2 !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", rdy2); end
    checks++; if (mi2.req_in_1 !== 27'd3) begin errors++; $display("FAIL single_op1 got %0d exp 3", mi2.req_in_1); end
    tick();
    v2 = '0;
    #2;
    checks++; if (rv2 !== 2'b00) begin errors++; $display("FAIL single_early got %b exp 00", rv2); end
    checks++; if (idle2 !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", idle2); end
    tick();
    #2;
    checks++; if (rv2 !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got %b exp 01", rv2); end
    checks++; if (ro2 !== 54'd15) begin errors++; $display("FAIL single_rsp_out got %0d exp 15", ro2); end
    tick();
    #2;
    checks++; if (rv2 !== 2'b00) begin errors++; $display("FAIL single_rsp_once got %b exp 00", rv2); end
    checks++; if (idle2 !== 1'b1) begin errors++; $display("FAIL single_idle got %b exp 1", idle2); end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0]  erv [10];
    logic [53:0] eo  [10];
    logic [1:0]  eg;
    for (int k = 0; k < 10; k++) begin erv[k] = '0; eo[k] = '0; end
    rst_dut2();
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        v2 = 2'b11;
        for (int i = 0; i < 2; i++) begin a2[i] = 27'($urandom); b2[i] = 27'($urandom); end
        eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      end else begin
        v2 = '0;
        eg = 2'b00;
      end
      #2;
      checks++; if (rdy2 !== eg) begin errors++; $display("FAIL cont_grant[%0d] got %b exp %b", k, rdy2, eg); end
      checks++; if (rv2 !== erv[k]) begin errors++; $display("FAIL cont_rsp_valid[%0d] got %b exp %b", k, rv2, erv[k]); end
      if (erv[k] != 2'b00) begin
        checks++; if (ro2 !== eo[k]) begin errors++; $display("FAIL cont_rsp_out[%0d] got %0h exp %0h", k, ro2, eo[k]); end
      end
      if (k < 4) begin
        erv[k+2] = eg;
        eo[k+2]  = pr(a2[k % 2], b2[k % 2]);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [3:0]  gs [3];
    logic [53:0] ps [3];
    rst4 = 1'b1; v4 = '0;
    tick();
    rst4 = 1'b0;
    for (int i = 0; i < 4; i++) begin a4[i] = 27'($urandom); b4[i] = 27'($urandom); end
    gs[0] = 4'b0100; gs[1] = 4'b1000; gs[2] = 4'b0001;
    ps[0] = pr(a4[2], b4[2]); ps[1] = pr(a4[3], b4[3]); ps[2] = pr(a4[0], b4[0]);
    for (int k = 0; k < 6; k++) begin
      v4 = (k == 0) ? 4'b0100 : (k < 3) ? 4'b1001 : 4'b0000;
      #2;
      if (k < 3) begin
        checks++; if (rdy4 !== gs[k]) begin errors++; $display("FAIL wrap_grant[%0d] got %b exp %b", k, rdy4, gs[k]); end
      end
      if (k >= 2 && k < 5) begin
        checks++; if (rv4 !== gs[k-2]) begin errors++; $display("FAIL wrap_rsp_valid[%0d] got %b exp %b", k, rv4, gs[k-2]); end
        checks++; if (ro4 !== ps[k-2]) begin errors++; $display("FAIL wrap_rsp_out[%0d] got %0h exp %0h", k, ro4, ps[k-2]); end
      end
      if (k == 5) begin
        checks++; if (idle4 !== 1'b1) begin errors++; $display("FAIL wrap_idle got %b exp 1", idle4); end
      end
      tick();
    end
  endtask

  task automatic test_reset_flight();
    rst_dut2();
    v2 = 2'b01; a2[0] = 27'($urandom); b2[0] = 27'($urandom);
    #2;
    checks++; if (mi2.en !== 1'b1) begin errors++; $display("FAIL rflt_issue got %b exp 1", mi2.en); end
    tick();
    rst2 = 1'b1; v2 = 2'b11;
    #2;
    checks++; if (rdy2 !== 2'b00) begin errors++; $display("FAIL rflt_ready got %b exp 00", rdy2); end
    checks++; if (mi2.en !== 1'b0) begin errors++; $display("FAIL rflt_en got %b exp 0", mi2.en); end
    tick();
    rst2 = 1'b0; v2 = '0;
    for (int c = 2; c <= 4; c++) begin
      #2;
      checks++; if (rv2 !== 2'b00) begin errors++; $display("FAIL rflt_rsp[%0d] got %b exp 00", c, rv2); end
      checks++; if (idle2 !== 1'b1) begin errors++; $display("FAIL rflt_idle[%0d] got %b exp 1", c, idle2); end
      tick();
    end
  endtask

`ifdef MUL_SHARE_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] sv [9], sl [9], sg [9];
    rst_dut2();
    // hold lock 3 cycles, unlock issue, then req1; then lock + owner drop
    sv = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
    sl = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    sg = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00};
    for (int k = 0; k < 9; k++) begin
      v2 = sv[k]; lk2 = sl[k];
      a2[0] = 27'($urandom); b2[0] = 27'($urandom);
      #2;
      checks++; if (rdy2 !== sg[k]) begin errors++; $display("FAIL lock_grant[%0d] got %b exp %b", k, rdy2, sg[k]); end
      tick();
    end
    lk2 = '0;
    tick(); tick();
    #2;
    checks++; if (idle2 !== 1'b1) begin errors++; $display("FAIL lock_idle got %b exp 1", idle2); end
    tick();
  endtask
`endif

  localparam int NCYC = 10000;
  int          eid [NCYC+8];
  logic [53:0] sbq [3][$];

  task automatic test_random();
    int         mp, g, id;
    logic [2:0] erdy, erv;
    logic [53:0] ep;
    mp = 0;
    for (int k = 0; k < NCYC + 8; k++) eid[k] = -1;
    rst3 = 1'b1; v3 = '0;
    tick();
    rst3 = 1'b0;
    for (int k = 0; k < NCYC + 4; k++) begin
      if (k < NCYC) begin
        v3 = 3'($urandom);
        for (int i = 0; i < 3; i++) begin a3[i] = 27'($urandom); b3[i] = 27'($urandom); end
      end else v3 = '0;
      #2;
      g = -1;
      for (int s = 0; s < 3; s++) if (g < 0 && v3[(mp + s) % 3]) g = (mp + s) % 3;
      erdy = (g < 0) ? 3'b000 : 3'(1 << g);
      checks++; if (rdy3 !== erdy) begin errors++; $display("FAIL rnd_grant[%0d] got %b exp %b", k, rdy3, erdy); end
      checks++; if ($countones(rdy3) > 1) begin errors++; $display("FAIL rnd_onehot[%0d] got %b exp at most one", k, rdy3); end
      id  = eid[k];
      erv = (id < 0) ? 3'b000 : 3'(1 << id);
      checks++; if (rv3 !== erv) begin errors++; $display("FAIL rnd_rsp_valid[%0d] got %b exp %b", k, rv3, erv); end
      if (id >= 0) begin
        ep = sbq[id].pop_front();
        checks++; if (ro3 !== ep) begin errors++; $display("FAIL rnd_rsp_out[%0d] got %0h exp %0h", k, ro3, ep); end
      end
      if (g >= 0) begin
        sbq[g].push_back(pr(a3[g], b3[g]));
        eid[k+3] = g;
        mp = (g + 1) % 3;
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (sbq[i].size() != 0) begin errors++; $display("FAIL rnd_drain[%0d] got %0d left exp 0", i, sbq[i].size()); end
    end
    #2;
    checks++; if (idle3 !== 1'b1) begin errors++; $display("FAIL rnd_idle got %b exp 1", idle3); end
  endtask

  initial begin
    rst4 = 1'b1; rst3 = 1'b1;
    tick();
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_reset_flight();
`ifdef MUL_SHARE_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
